// File: rtl/qe_wiz_bus_sequencer_if.sv
// QL expansion-bus / W5300 signal bundle for qe_wiz_bus_sequencer.
// The wired-bus pins dtackl and dsmcl are tristate and stay plain ports on the sequencer.
interface qe_wiz_bus_sequencer_if;
    logic [9:0] address;
    logic       asl;
    logic       dsl;
    logic       rdwl;
    logic       dbenl;
    logic       dbdir;
    logic       wizcsl;
    logic       wizrdl;
    logic       wizwrl;
    logic       wizrstl;
    logic       busy;

    modport master (
        output address, asl, dsl, rdwl,
        input  dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl, busy
    );

    modport slave (
        input  address, asl, dsl, rdwl,
        output dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl, busy
    );
endinterface

// File: rtl/qe_wiz_bus_sequencer.sv
// Clocked QL 68008 expansion-bus to W5300 sequencer: card-window decode, timed W5300
// strobes, DTACK generation and the W5300 hardware-reset / PLL-lock sequence.
module qe_wiz_bus_sequencer #(
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 4,
    parameter int HOLD_CYC     = 1,
    parameter int RECOVER_CYC  = 2,
    parameter int RST_LOW_CYC  = 40,
    parameter int RST_WAIT_CYC = 200000,
    parameter int CNT_W        = 24
) (
    input  logic                  clk,
    input  logic                  resetl,
    qe_wiz_bus_sequencer_if.slave bus,
    output wire                   dtackl,
    output wire                   dsmcl
);
    typedef enum logic [3:0] {
        S_RST_LOW, S_RST_WAIT, S_IDLE, S_SETUP, S_STROBE,
        S_HOLD_ACK, S_WAIT_DS, S_WHOLD, S_RECOVER
    } state_t;

    typedef enum logic [1:0] { K_WIZ, K_DUM, K_RST } kind_t;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic wizrstl;
        logic wizcsl;
        logic wizrdl;
        logic wizwrl;
        logic dtack;
        logic dsmc;
        logic dbenl;
        logic dbdir;
        logic busy;
    } out_t;

    localparam out_t OUT_RESET = '{wizrstl: 1'b0, wizcsl: 1'b1, wizrdl: 1'b1, wizwrl: 1'b1,
                                   dtack: 1'b0, dsmc: 1'b0, dbenl: 1'b1, dbdir: 1'b1,
                                   busy: 1'b1};

    function automatic cnt_t entry_load(state_t s);
        case (s)
            S_RST_LOW:  return cnt_t'(RST_LOW_CYC - 1);
            S_RST_WAIT: return cnt_t'(RST_WAIT_CYC - 1);
            S_SETUP:    return cnt_t'(SETUP_CYC - 1);
            S_STROBE:   return cnt_t'(STROBE_CYC - 1);
            S_WHOLD:    return cnt_t'(HOLD_CYC - 1);
            S_RECOVER:  return cnt_t'(RECOVER_CYC - 1);
            default:    return '0;
        endcase
    endfunction

    state_t     state, state_next;
    cnt_t       timer;
    logic       timer_zero;
    logic       asl_meta, dsl_meta, rdwl_meta;
    logic       s_asl, s_dsl, s_rdwl;
    logic [9:0] addr_q;
    logic       card_hit, accept;
    kind_t      dec_kind, acc_kind, kind_eff;
    logic       acc_read, read_eff, rst_pend, is_wiz;
    out_t       out_d, out_q;

    // NOTE: every clocked process uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            {asl_meta, dsl_meta, rdwl_meta} <= 3'b111;
            {s_asl, s_dsl, s_rdwl}          <= 3'b111;
            addr_q                          <= '0;
        end else begin
            {asl_meta, dsl_meta, rdwl_meta} <= {bus.asl, bus.dsl, bus.rdwl};
            {s_asl, s_dsl, s_rdwl}          <= {asl_meta, dsl_meta, rdwl_meta};
            // Capture on the edge that makes s_asl low, so IDLE decodes a stable address.
            if (s_asl && !asl_meta) addr_q <= bus.address;
        end
    end

    // NOTE: each always_comb assigns defaults first so no path leaves a latch behind.
    always_comb begin
        card_hit = (addr_q[9:8] == 2'b00) && (addr_q[7:4] == 4'h4);
        dec_kind = K_DUM;
        if (addr_q[3:0] == 4'h8)                 dec_kind = K_WIZ;
        else if (addr_q[3:0] == 4'hC && !s_rdwl) dec_kind = K_RST;
        accept     = (state == S_IDLE) && !s_asl && !s_dsl && card_hit;
        kind_eff   = accept ? dec_kind : acc_kind;
        read_eff   = accept ? s_rdwl   : acc_read;
        timer_zero = (timer == '0);
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state    <= S_RST_LOW;
            timer    <= entry_load(S_RST_LOW);
            acc_kind <= K_DUM;
            acc_read <= 1'b1;
            rst_pend <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) timer <= entry_load(state_next);
            else if (!timer_zero)    timer <= timer - cnt_t'(1);
            acc_kind <= kind_eff;
            acc_read <= read_eff;
            if (accept)
                rst_pend <= (dec_kind == K_RST);
            else if (state == S_WAIT_DS && state_next == S_RST_LOW)
                rst_pend <= 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RST_LOW:  if (timer_zero) state_next = S_RST_WAIT;
            S_RST_WAIT: if (timer_zero) state_next = S_IDLE;
            S_IDLE:     if (accept) state_next = (dec_kind == K_RST) ? S_HOLD_ACK : S_SETUP;
            S_SETUP: begin
                if (s_asl)           state_next = S_RECOVER;
                else if (timer_zero) state_next = (acc_kind == K_WIZ) ? S_STROBE : S_HOLD_ACK;
            end
            S_STROBE: begin
                if (s_asl)           state_next = S_RECOVER;
                else if (timer_zero) state_next = S_HOLD_ACK;
            end
            S_HOLD_ACK: state_next = S_WAIT_DS;
            S_WAIT_DS: begin
                if (s_dsl) begin
                    if (rst_pend)      state_next = S_RST_LOW;
                    else if (acc_read) state_next = S_RECOVER;
                    else               state_next = S_WHOLD;
                end
            end
            S_WHOLD:   if (timer_zero) state_next = S_RECOVER;
            S_RECOVER: if (timer_zero) state_next = S_IDLE;
            default:   state_next = S_RST_LOW;
        endcase
    end

    // Outputs are decoded from the next state and registered, so pins change on clock edges only.
    always_comb begin
        is_wiz = (kind_eff == K_WIZ);
        out_d  = '{wizrstl: 1'b1, wizcsl: 1'b1, wizrdl: 1'b1, wizwrl: 1'b1, dtack: 1'b0,
                   dsmc: 1'b0, dbenl: 1'b1, dbdir: read_eff, busy: (state_next != S_IDLE)};
        case (state_next)
            S_RST_LOW: out_d.wizrstl = 1'b0;
            S_SETUP, S_WHOLD: begin
                out_d.dsmc   = 1'b1;
                out_d.dbenl  = 1'b0;
                out_d.wizcsl = ~is_wiz;
            end
            S_STROBE, S_HOLD_ACK, S_WAIT_DS: begin
                out_d.dsmc   = 1'b1;
                out_d.dbenl  = 1'b0;
                out_d.wizcsl = ~is_wiz;
                out_d.wizrdl = ~(is_wiz & read_eff);
                out_d.wizwrl = ~(is_wiz & ~read_eff);
                out_d.dtack  = (state_next != S_STROBE);
            end
            S_RECOVER: out_d.dsmc = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) out_q <= OUT_RESET;
        else         out_q <= out_d;
    end

    assign bus.wizrstl = out_q.wizrstl;
    assign bus.wizcsl  = out_q.wizcsl;
    assign bus.wizrdl  = out_q.wizrdl;
    assign bus.wizwrl  = out_q.wizwrl;
    assign bus.dbenl   = out_q.dbenl;
    assign bus.dbdir   = out_q.dbdir;
    assign bus.busy    = out_q.busy;
    assign dtackl      = out_q.dtack ? 1'b0 : 1'bz;
    assign dsmcl       = out_q.dsmc  ? 1'b1 : 1'bz;
endmodule
